// File: rtl/multimode_ring_counter_if.sv
// rtl/multimode_ring_counter_if.sv - control and status bundle for the ring/Johnson counter
interface multimode_ring_counter_if #(
    parameter int WIDTH = 4
);
    localparam int STEP_W = $clog2(2 * WIDTH);

    logic              en;
    logic              mode;
    logic              dir;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  out;
    logic [STEP_W-1:0] step;
    logic              wrap;
    logic              illegal;

    modport master (
        output en, mode, dir, load, load_val,
        input  out, step, wrap, illegal
    );

    modport slave (
        input  en, mode, dir, load, load_val,
        output out, step, wrap, illegal
    );
endinterface

// File: rtl/multimode_ring_counter.sv
// rtl/multimode_ring_counter.sv - ring / Johnson shift counter with step index, wrap pulse and self-correction
module multimode_ring_counter #(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] SEED         = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter bit               SELF_CORRECT = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    multimode_ring_counter_if.slave  bus
);
    localparam int STEP_W = $clog2(2 * WIDTH);

    logic [WIDTH-1:0]  out_q, out_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              wrap_q, wrap_d;

    logic [WIDTH-2:0]  edges;
    logic              illegal;
    logic              feedback;
    logic [WIDTH-1:0]  shifted;
    logic [STEP_W-1:0] last_step;

    // Legality: ring needs exactly one hot bit; Johnson allows at most one 0/1 boundary.
    always_comb begin
        edges = out_q[WIDTH-1:1] ^ out_q[WIDTH-2:0];
        if (bus.mode) begin
            illegal = ($countones(edges) > 1);
        end else begin
            illegal = ($countones(out_q) != 1);
        end
    end

    // One step of the sequence in the requested direction; Johnson inverts the wrapped bit.
    always_comb begin
        if (bus.dir) begin
            feedback = out_q[WIDTH-1] ^ bus.mode;
            shifted  = {out_q[WIDTH-2:0], feedback};
        end else begin
            feedback = out_q[0] ^ bus.mode;
            shifted  = {feedback, out_q[WIDTH-1:1]};
        end
        last_step = bus.mode ? STEP_W'(2 * WIDTH - 1) : STEP_W'(WIDTH - 1);
    end

    // Next state: load > correction > advance > hold (reset handled in the register).
    always_comb begin
        out_d  = out_q;
        step_d = step_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            out_d  = bus.load_val;
            step_d = '0;
        end else if (SELF_CORRECT && illegal) begin
            out_d  = SEED;
            step_d = '0;
        end else if (bus.en) begin
            out_d = shifted;
            if (step_q >= last_step) begin
                step_d = '0;
                wrap_d = 1'b1;
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= SEED;
            step_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.step    = step_q;
    assign bus.wrap    = wrap_q;
    assign bus.illegal = illegal;
endmodule

// File: tb/tb_multimode_ring_counter.sv
// tb/tb_multimode_ring_counter.sv - randomized self-checking bench for multimode_ring_counter
module tb_multimode_ring_counter;
    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multimode_ring_counter_if #(.WIDTH(W)) bus_sc ();
    multimode_ring_counter_if #(.WIDTH(W)) bus_nc ();

    multimode_ring_counter #(.WIDTH(W), .SEED(4'b0001), .SELF_CORRECT(1'b1)) u_sc (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_sc)
    );

    multimode_ring_counter #(.WIDTH(W), .SEED(4'b0001), .SELF_CORRECT(1'b0)) u_nc (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: index 0 self-correcting, index 1 report-only.
    int m_out  [2];
    int m_step [2];
    int m_wrap [2];

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_cmp++;
        if (got !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit legal(input int v, input bit md);
        if (!md) return (v != 0) && ((v & (v - 1)) == 0);
        for (int k = 0; k <= W; k++) begin
            if (v == ((((1 << k) - 1) << (W - k)) & MASK)) return 1'b1;
            if (v == ((1 << (W - k)) - 1)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_edge(input bit r, input bit ld, input int lv,
                              input bit e, input bit md, input bit d);
        for (int u = 0; u < 2; u++) begin
            int period;
            int v;
            int fb;
            period = md ? 2 * W : W;
            if (r) begin
                m_out[u] = 1; m_step[u] = 0; m_wrap[u] = 0;
            end else if (ld) begin
                m_out[u] = lv; m_step[u] = 0; m_wrap[u] = 0;
            end else if (u == 0 && !legal(m_out[u], md)) begin
                m_out[u] = 1; m_step[u] = 0; m_wrap[u] = 0;
            end else if (e) begin
                v  = m_out[u];
                fb = d ? ((v >> (W - 1)) & 1) : (v & 1);
                if (md) fb = fb ^ 1;
                m_out[u]  = d ? (((v << 1) & MASK) | fb) : ((v >> 1) | (fb << (W - 1)));
                m_step[u] = (m_step[u] >= period - 1) ? 0 : m_step[u] + 1;
                m_wrap[u] = (m_step[u] == 0) ? 1 : 0;
            end else begin
                m_wrap[u] = 0;
            end
        end
    endtask

    task automatic apply(input bit r, input bit ld, input int lv,
                         input bit e, input bit md, input bit d);
        reset = r;
        bus_sc.load = ld; bus_sc.load_val = 4'(lv); bus_sc.en = e; bus_sc.mode = md; bus_sc.dir = d;
        bus_nc.load = ld; bus_nc.load_val = 4'(lv); bus_nc.en = e; bus_nc.mode = md; bus_nc.dir = d;
        #1;
        chk("illegal_sc", 32'(bus_sc.illegal), legal(m_out[0], md) ? 0 : 1);
        chk("illegal_nc", 32'(bus_nc.illegal), legal(m_out[1], md) ? 0 : 1);
        @(posedge clk);
        model_edge(r, ld, lv, e, md, d);
        @(negedge clk);
        chk("out_sc",  32'(bus_sc.out),  m_out[0]);
        chk("step_sc", 32'(bus_sc.step), m_step[0]);
        chk("wrap_sc", 32'(bus_sc.wrap), m_wrap[0]);
        chk("out_nc",  32'(bus_nc.out),  m_out[1]);
        chk("step_nc", 32'(bus_nc.step), m_step[1]);
        chk("wrap_nc", 32'(bus_nc.wrap), m_wrap[1]);
    endtask

    initial begin
        int ring_seq [4];
        bit md;
        bit d;
        ring_seq = '{8, 4, 2, 1};
        m_out  = '{1, 1};
        m_step = '{0, 0};
        m_wrap = '{0, 0};
        bus_sc.en = 0; bus_sc.mode = 0; bus_sc.dir = 0; bus_sc.load = 0; bus_sc.load_val = '0;
        bus_nc.en = 0; bus_nc.mode = 0; bus_nc.dir = 0; bus_nc.load = 0; bus_nc.load_val = '0;
        @(negedge clk);

        // Reset, then ring toward LSB with explicit expected sequence.
        apply(1, 0, 0, 0, 0, 0);
        chk("reset_out", 32'(bus_sc.out), 1);
        chk("reset_step", 32'(bus_sc.step), 0);
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 1, 0, 0);
            chk("ring_seq", 32'(bus_sc.out), ring_seq[i]);
            chk("ring_wrap", 32'(bus_sc.wrap), (i == 3) ? 1 : 0);
        end

        // Johnson toward LSB, full period of 8.
        for (int i = 0; i < 8; i++) apply(0, 0, 0, 1, 1, 0);
        chk("johnson_end", 32'(bus_sc.out), 1);
        chk("johnson_wrap", 32'(bus_sc.wrap), 1);

        // Ring toward MSB.
        for (int i = 0; i < 4; i++) apply(0, 0, 0, 1, 0, 1);

        // Illegal load: correction versus report-only rotation.
        apply(0, 1, 4'b0110, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        chk("corrected", 32'(bus_sc.out), 1);
        apply(0, 1, 4'b0110, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0);
        chk("nc_rotated", 32'(bus_nc.out), 4'b0011);

        // Hold and load-over-enable.
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0);
        apply(0, 1, 4'b0100, 1, 0, 0);

        // Reset beats load mid-sequence.
        apply(0, 0, 0, 1, 0, 0);
        apply(1, 1, 4'b1000, 1, 0, 0);

        // Johnson 0111 becomes illegal immediately on switching to ring.
        apply(0, 1, 4'b0111, 0, 1, 0);
        apply(0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        md = 0;
        d  = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) md = ~md;
            if ($urandom_range(0, 7) == 0) d  = ~d;
            apply($urandom_range(0, 49) == 0,
                  $urandom_range(0, 11) == 0,
                  int'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0,
                  md, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
